// File: rtl/vc_allocator.sv
// ---------------------------------------------------------------------------
// vc_allocator
//   Output-VC allocator for one router output stage. Performs separable
//   input-first allocation: each requesting input VC first narrows its
//   candidate mask to a single output VC (stage 1), then each output VC picks
//   one of the requesters that chose it using a round-robin pointer (stage 2).
//   Grants are combinational from the current request and busy state; the
//   busy mask and round-robin pointers update on the clock edge.
//
// Configuration macro:
//   VA_RR_STAGE1_EN  - when defined, stage 1 uses a per-requester round-robin
//                      pointer instead of fixed lowest-index priority.
//
// Ports:
//   clk        in   1       clock
//   rst        in   1       asynchronous reset, active-high
//   reqVC      in   NIN*CN  requester i candidate-VC mask in [i*CN +: CN]
//   selOutVC   out  NIN*CN  requester i one-hot granted VC in [i*CN +: CN]
//   VCgranted  out  NIN     requester i granted this cycle
//   vc_release in   CN      per-VC pulse: tail flit of output VC j departed
//   vc_busy    out  CN      registered busy mask
// ---------------------------------------------------------------------------
module vc_allocator #(
  parameter int CN  = 6,
  parameter int NIN = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIN*CN-1:0] reqVC,
  output logic [NIN*CN-1:0] selOutVC,
  output logic [NIN-1:0]    VCgranted,
  input  logic [CN-1:0]     vc_release,
  output logic [CN-1:0]     vc_busy
);

  localparam int P1W = (CN  > 1) ? $clog2(CN)  : 1;
  localparam int P2W = (NIN > 1) ? $clog2(NIN) : 1;

  logic [CN-1:0]                busy_q, busy_d;
  logic [CN-1:0][P2W-1:0]       ptr2_q, ptr2_d;
  logic [NIN-1:0][CN-1:0]       ereq;
  logic [NIN-1:0][CN-1:0]       cand;
  logic [NIN-1:0][CN-1:0]       selVec;
  logic [CN-1:0][NIN-1:0]       column;
  logic [CN-1:0][NIN-1:0]       win;
  logic [CN-1:0]                grantMask;

`ifdef VA_RR_STAGE1_EN
  logic [NIN-1:0][P1W-1:0]      ptr1_q, ptr1_d;
`endif

  // Isolate the lowest set bit with the two's-complement trick.
  function automatic logic [CN-1:0] lowestCn(input logic [CN-1:0] x);
    return x & (~x + CN'(1));
  endfunction

  function automatic logic [NIN-1:0] lowestNin(input logic [NIN-1:0] x);
    return x & (~x + NIN'(1));
  endfunction

  // Round-robin pick: prefer the lowest request at or above the pointer,
  // otherwise wrap around and take the lowest request overall.
  function automatic logic [CN-1:0] rrPickCn(input logic [CN-1:0] req,
                                             input logic [P1W-1:0] ptr);
    logic [CN-1:0] hi;
    hi = req & ({CN{1'b1}} << ptr);
    return (hi != '0) ? lowestCn(hi) : lowestCn(req);
  endfunction

  function automatic logic [NIN-1:0] rrPickNin(input logic [NIN-1:0] req,
                                               input logic [P2W-1:0] ptr);
    logic [NIN-1:0] hi;
    hi = req & ({NIN{1'b1}} << ptr);
    return (hi != '0) ? lowestNin(hi) : lowestNin(req);
  endfunction

  // Pointer value one past the position of a one-hot vector, wrapping.
  function automatic logic [P2W-1:0] nextNin(input logic [NIN-1:0] oh);
    logic [P2W-1:0] r;
    r = '0;
    for (int k = 0; k < NIN; k++) begin
      if (oh[k]) r = (k == NIN - 1) ? '0 : P2W'(k + 1);
    end
    return r;
  endfunction

`ifdef VA_RR_STAGE1_EN
  function automatic logic [P1W-1:0] nextCn(input logic [CN-1:0] oh);
    logic [P1W-1:0] r;
    r = '0;
    for (int k = 0; k < CN; k++) begin
      if (oh[k]) r = (k == CN - 1) ? '0 : P1W'(k + 1);
    end
    return r;
  endfunction
`endif

  // Stage 1: each requester masks out busy VCs and keeps a single candidate.
  always_comb begin
    ereq = '0;
    cand = '0;
    for (int i = 0; i < NIN; i++) begin
      ereq[i] = reqVC[i*CN +: CN] & ~busy_q;
`ifdef VA_RR_STAGE1_EN
      cand[i] = rrPickCn(ereq[i], ptr1_q[i]);
`else
      cand[i] = lowestCn(ereq[i]);
`endif
    end
  end

  // Stage 2: each output VC arbitrates among the requesters that chose it.
  // A winner always has the VC as its sole candidate, so the transposed win
  // matrix is directly the per-requester one-hot grant.
  always_comb begin
    column    = '0;
    win       = '0;
    grantMask = '0;
    selVec    = '0;
    for (int j = 0; j < CN; j++) begin
      for (int i = 0; i < NIN; i++) begin
        column[j][i] = cand[i][j];
      end
      win[j]       = rrPickNin(column[j], ptr2_q[j]);
      grantMask[j] = |win[j];
    end
    for (int i = 0; i < NIN; i++) begin
      for (int j = 0; j < CN; j++) begin
        selVec[i][j] = win[j][i];
      end
    end
  end

  always_comb begin
    selOutVC  = '0;
    VCgranted = '0;
    for (int i = 0; i < NIN; i++) begin
      selOutVC[i*CN +: CN] = selVec[i];
      VCgranted[i]         = |selVec[i];
    end
  end

  // Next state: release is applied after the grant so that a release pulse on
  // a free VC being granted in the same cycle leaves it free.
  always_comb begin
    busy_d = (busy_q | grantMask) & ~vc_release;
    ptr2_d = ptr2_q;
    for (int j = 0; j < CN; j++) begin
      if (grantMask[j]) ptr2_d[j] = nextNin(win[j]);
    end
  end

`ifdef VA_RR_STAGE1_EN
  always_comb begin
    ptr1_d = ptr1_q;
    for (int i = 0; i < NIN; i++) begin
      if (VCgranted[i]) ptr1_d[i] = nextCn(selVec[i]);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      ptr2_q <= '0;
`ifdef VA_RR_STAGE1_EN
      ptr1_q <= '0;
`endif
    end else begin
      busy_q <= busy_d;
      ptr2_q <= ptr2_d;
`ifdef VA_RR_STAGE1_EN
      ptr1_q <= ptr1_d;
`endif
    end
  end

  assign vc_busy = busy_q;

endmodule

// File: tb/tb_vc_allocator.sv
// ---------------------------------------------------------------------------
// tb_vc_allocator
//   Directed checks of the output-VC allocator (default build: fixed
//   lowest-index stage 1, round-robin stage 2) plus a short random run that
//   checks allocation invariants against an independent busy-mask model.
// ---------------------------------------------------------------------------
module tb_vc_allocator;

  localparam int CN  = 6;
  localparam int NIN = 6;

  logic              clk;
  logic              rst;
  logic [NIN*CN-1:0] reqVC;
  logic [NIN*CN-1:0] selOutVC;
  logic [NIN-1:0]    VCgranted;
  logic [CN-1:0]     vc_release;
  logic [CN-1:0]     vc_busy;

  int testsRun    = 0;
  int testsFailed = 0;

  vc_allocator #(.CN(CN), .NIN(NIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .reqVC      (reqVC),
    .selOutVC   (selOutVC),
    .VCgranted  (VCgranted),
    .vc_release (vc_release),
    .vc_busy    (vc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst        = 1'b1;
    reqVC      = '0;
    vc_release = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic setReq(input int idx, input logic [CN-1:0] m);
    reqVC[idx*CN +: CN] = m;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    reqVC      = '0;
    vc_release = '0;
    #2;
    testsRun++;
    if (vc_busy !== 6'b000000) begin
      testsFailed++;
      $display("[TB] FAIL reset_busy: got %b expected %b", vc_busy, 6'b000000);
    end
    testsRun++;
    if (VCgranted !== 6'b000000) begin
      testsFailed++;
      $display("[TB] FAIL reset_granted: got %b expected %b", VCgranted, 6'b000000);
    end
    testsRun++;
    if (selOutVC !== 36'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_sel: got %h expected %h", selOutVC, 36'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_grant();
    doReset();
    setReq(0, 6'b000110);
    #1;
    testsRun++;
    if (selOutVC !== 36'h2) begin
      testsFailed++;
      $display("[TB] FAIL single_sel: got %h expected %h", selOutVC, 36'h2);
    end
    testsRun++;
    if (VCgranted !== 6'b000001) begin
      testsFailed++;
      $display("[TB] FAIL single_granted: got %b expected %b", VCgranted, 6'b000001);
    end
    tick();
    reqVC = '0;
    #1;
    testsRun++;
    if (vc_busy !== 6'b000010) begin
      testsFailed++;
      $display("[TB] FAIL single_busy: got %b expected %b", vc_busy, 6'b000010);
    end
  endtask

  task automatic test_busy_block_release();
    doReset();
    setReq(0, 6'b000001);
    setReq(1, 6'b000001);
    setReq(2, 6'b000001);
    #1;
    testsRun++;
    if (VCgranted !== 6'b000001 || selOutVC !== 36'h1) begin
      testsFailed++;
      $display("[TB] FAIL hold_cyc0: got %b/%h expected %b/%h", VCgranted, selOutVC, 6'b000001, 36'h1);
    end
    tick();
    testsRun++;
    if (VCgranted !== 6'b000000 || vc_busy !== 6'b000001) begin
      testsFailed++;
      $display("[TB] FAIL hold_cyc1: got %b busy %b expected %b busy %b", VCgranted, vc_busy, 6'b000000, 6'b000001);
    end
    tick();
    testsRun++;
    if (VCgranted !== 6'b000000) begin
      testsFailed++;
      $display("[TB] FAIL hold_cyc2: got %b expected %b", VCgranted, 6'b000000);
    end
    vc_release = 6'b000001;
    #1;
    testsRun++;
    if (VCgranted !== 6'b000000) begin
      testsFailed++;
      $display("[TB] FAIL release_no_bypass: got %b expected %b", VCgranted, 6'b000000);
    end
    tick();
    vc_release = '0;
    #1;
    testsRun++;
    if (VCgranted !== 6'b000010 || selOutVC !== 36'h40) begin
      testsFailed++;
      $display("[TB] FAIL release_winner: got %b/%h expected %b/%h", VCgranted, selOutVC, 6'b000010, 36'h40);
    end
  endtask

  // Three requesters share VC0; each grant/release pair should advance the
  // winner 0,1,2 and then wrap back to 0.
  task automatic test_rr_rotation();
    logic [NIN-1:0] expG;
    doReset();
    setReq(0, 6'b000001);
    setReq(1, 6'b000001);
    setReq(2, 6'b000001);
    for (int k = 0; k < 6; k++) begin
      expG = NIN'(1) << (k % 3);
      #1;
      testsRun++;
      if (VCgranted !== expG) begin
        testsFailed++;
        $display("[TB] FAIL rr_step%0d: got %b expected %b", k, VCgranted, expG);
      end
      tick();
      vc_release = 6'b000001;
      tick();
      vc_release = '0;
    end
  endtask

  task automatic test_all_busy();
    doReset();
    for (int i = 0; i < NIN; i++) setReq(i, CN'(1) << i);
    #1;
    testsRun++;
    if (VCgranted !== 6'b111111) begin
      testsFailed++;
      $display("[TB] FAIL fill_granted: got %b expected %b", VCgranted, 6'b111111);
    end
    tick();
    testsRun++;
    if (vc_busy !== 6'b111111 || VCgranted !== 6'b000000) begin
      testsFailed++;
      $display("[TB] FAIL allbusy: got busy %b granted %b expected busy %b granted %b", vc_busy, VCgranted, 6'b111111, 6'b000000);
    end
    vc_release = 6'b000100;
    #1;
    testsRun++;
    if (VCgranted !== 6'b000000) begin
      testsFailed++;
      $display("[TB] FAIL allbusy_release_cycle: got %b expected %b", VCgranted, 6'b000000);
    end
    tick();
    vc_release = '0;
    #1;
    testsRun++;
    if (VCgranted !== 6'b000100 || selOutVC !== 36'h4000) begin
      testsFailed++;
      $display("[TB] FAIL allbusy_vc2_grant: got %b/%h expected %b/%h", VCgranted, selOutVC, 6'b000100, 36'h4000);
    end
    tick();
    testsRun++;
    if (vc_busy !== 6'b111111) begin
      testsFailed++;
      $display("[TB] FAIL allbusy_refill: got %b expected %b", vc_busy, 6'b111111);
    end
  endtask

  task automatic test_stage1_conflict();
    doReset();
    setReq(0, 6'b000011);
    setReq(1, 6'b000011);
    #1;
    testsRun++;
    if (VCgranted !== 6'b000001 || selOutVC !== 36'h1) begin
      testsFailed++;
      $display("[TB] FAIL conflict_same: got %b/%h expected %b/%h", VCgranted, selOutVC, 6'b000001, 36'h1);
    end
    setReq(1, 6'b000010);
    #1;
    testsRun++;
    if (VCgranted !== 6'b000011 || selOutVC !== 36'h81) begin
      testsFailed++;
      $display("[TB] FAIL conflict_disjoint: got %b/%h expected %b/%h", VCgranted, selOutVC, 6'b000011, 36'h81);
    end
  endtask

  task automatic test_release_and_reset();
    doReset();
    setReq(0, 6'b000010);
    tick();
    reqVC = '0;
    vc_release = 6'b001000;
    tick();
    vc_release = '0;
    #1;
    testsRun++;
    if (vc_busy !== 6'b000010) begin
      testsFailed++;
      $display("[TB] FAIL release_free: got %b expected %b", vc_busy, 6'b000010);
    end
    setReq(0, 6'b001000);
    vc_release = 6'b001000;
    #1;
    testsRun++;
    if (VCgranted !== 6'b000001) begin
      testsFailed++;
      $display("[TB] FAIL grant_with_release: got %b expected %b", VCgranted, 6'b000001);
    end
    tick();
    reqVC = '0;
    vc_release = '0;
    #1;
    testsRun++;
    if (vc_busy !== 6'b000010) begin
      testsFailed++;
      $display("[TB] FAIL release_wins: got %b expected %b", vc_busy, 6'b000010);
    end
    setReq(0, 6'b001000);
    setReq(1, 6'b100000);
    tick();
    testsRun++;
    if (vc_busy !== 6'b101010) begin
      testsFailed++;
      $display("[TB] FAIL midtraffic_busy: got %b expected %b", vc_busy, 6'b101010);
    end
    #2;
    rst = 1'b1;
    #1;
    testsRun++;
    if (vc_busy !== 6'b000000) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_busy: got %b expected %b", vc_busy, 6'b000000);
    end
    reqVC = '0;
    #1;
    testsRun++;
    if (VCgranted !== 6'b000000 || selOutVC !== 36'h0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_grant: got %b/%h expected %b/%h", VCgranted, selOutVC, 6'b000000, 36'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Random traffic: structural grant invariants and a busy-mask model.
  task automatic test_random();
    logic [CN-1:0] mBusy;
    logic [CN-1:0] gMask;
    logic [CN-1:0] s;
    logic          anyEreq;
    logic          ok;
    int            cnt;
    doReset();
    mBusy = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      reqVC      = (NIN*CN)'({$urandom(), $urandom()});
      vc_release = CN'($urandom() & $urandom());
      #1;
      ok      = 1'b1;
      gMask   = '0;
      anyEreq = 1'b0;
      for (int j = 0; j < CN; j++) begin
        cnt = 0;
        for (int i = 0; i < NIN; i++) if (selOutVC[i*CN + j]) cnt++;
        if (cnt > 1) ok = 1'b0;
      end
      for (int i = 0; i < NIN; i++) begin
        s = selOutVC[i*CN +: CN];
        gMask = gMask | s;
        if ((s & (s - CN'(1))) != '0) ok = 1'b0;
        if (VCgranted[i] !== (|s)) ok = 1'b0;
        if ((s & ~reqVC[i*CN +: CN]) != '0) ok = 1'b0;
        if ((reqVC[i*CN +: CN] & ~mBusy) != '0) anyEreq = 1'b1;
      end
      if ((gMask & mBusy) != '0) ok = 1'b0;
      if (anyEreq && gMask == '0) ok = 1'b0;
      testsRun++;
      if (!ok) begin
        testsFailed++;
        $display("[TB] FAIL rand_invariant cyc%0d: got sel %h granted %b busy %b expected legal grant over model busy %b", cyc, selOutVC, VCgranted, vc_busy, mBusy);
      end
      mBusy = (mBusy | gMask) & ~vc_release;
      tick();
      testsRun++;
      if (vc_busy !== mBusy) begin
        testsFailed++;
        $display("[TB] FAIL rand_busy cyc%0d: got %b expected %b", cyc, vc_busy, mBusy);
      end
    end
    reqVC      = '0;
    vc_release = '0;
  endtask

  initial begin
    rst        = 1'b1;
    reqVC      = '0;
    vc_release = '0;
    test_reset();
    test_single_grant();
    test_busy_block_release();
    test_rr_rotation();
    test_all_busy();
    test_stage1_conflict();
    test_release_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
